ultrasonic_scan3: RTL and testbench

//  Upstream ranging stage for the avoidance controller. Fires three ultrasonic

---
 rtl/ultrasonic_scan3_pkg.sv | 31 +++
 rtl/ultrasonic_scan3_echo_meter.sv | 70 +++++++
 rtl/ultrasonic_scan3.sv | 198 +++++++++++++++++++
 tb/tb_ultrasonic_scan3.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_scan3_pkg.sv
// Shared types and constants for the three-sensor ultrasonic ranging stage.
package ultrasonic_scan3_pkg;

    localparam int unsigned DIST_W = 8;

    localparam logic [DIST_W-1:0] DIST_MAX   = 8'd255;  // nothing in range / saturated
    localparam logic [DIST_W-1:0] DIST_FAULT = 8'd0;    // stuck echo, treated as blocked

    typedef enum logic [1:0] {
        CH_M = 2'd0,
        CH_R = 2'd1,
        CH_L = 2'd2
    } ch_e;

    typedef enum logic [1:0] {
        S_TRIG      = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_MEASURE   = 2'd2,
        S_GAP       = 2'd3
    } state_e;

    // Round-robin firing order M -> R -> L -> M
    function automatic ch_e next_ch(input ch_e ch);
        case (ch)
            CH_M:    return CH_R;
            CH_R:    return CH_L;
            default: return CH_M;
        endcase
    endfunction

endpackage

// File: rtl/ultrasonic_scan3_echo_meter.sv
// Echo pulse meter: 2-FF synchronizer, edge detect, unit prescaler and a
// saturating distance counter. One instance is shared by all channels.
module ultrasonic_scan3_echo_meter
    import ultrasonic_scan3_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4375
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_echo,
    input  logic              i_clear,
    input  logic              i_run,
    output logic              o_level,
    output logic              o_rise_c,
    output logic              o_fall_c,
    output logic [DIST_W-1:0] o_count_nxt_c
);

    localparam int unsigned   PW         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_edge;
    logic [PW-1:0]     r_presc;
    logic [DIST_W-1:0] r_count;
    logic              w_wrap;

    // Synchronize the selected echo and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= i_echo;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    assign o_level  = r_sync2;
    assign o_rise_c = r_sync2 & ~r_edge;
    assign o_fall_c = ~r_sync2 & r_edge;
    assign w_wrap   = i_run && (r_presc == PRESC_LAST);

    // Count value including this cycle's unit wrap, so a write on the
    // terminating cycle sees every completed unit
    always_comb begin
        o_count_nxt_c = r_count;
        if (w_wrap && (r_count != DIST_MAX)) begin
            o_count_nxt_c = r_count + DIST_W'(1);
        end
    end

    // Prescaler divides clk into distance units; counter saturates at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_presc <= '0;
            r_count <= '0;
        end else if (i_run) begin
            r_presc <= w_wrap ? '0 : r_presc + PW'(1);
            r_count <= o_count_nxt_c;
        end
    end

endmodule

// File: rtl/ultrasonic_scan3.sv
// Three-sensor ultrasonic ranging stage: fires middle/right/left sensors in
// turn, measures each echo width in 1.5 cm units and holds the results.
module ultrasonic_scan3
    import ultrasonic_scan3_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4375,
    parameter int unsigned TRIG_CYCLES = 500,
    parameter int unsigned TIMEOUT_CYC = 1500000,
    parameter int unsigned GAP_CYCLES  = 2500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              echo_m,
    input  logic              echo_r,
    input  logic              echo_l,
    output logic              trig_m,
    output logic              trig_r,
    output logic              trig_l,
    output logic [DIST_W-1:0] dist_m,
    output logic [DIST_W-1:0] dist_r,
    output logic [DIST_W-1:0] dist_l,
    output logic              dist_upd,
    output logic [1:0]        upd_ch
);

    // One shared timer covers trigger width, echo timeout and inter-shot gap
    localparam int unsigned T_A    = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int unsigned T_MAX  = ((T_A > TIMEOUT_CYC) ? T_A : TIMEOUT_CYC) + 1;
    localparam int unsigned TW     = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] T_TRIG = TW'(TRIG_CYCLES);
    localparam logic [TW-1:0] T_TOUT = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T_GAP  = TW'(GAP_CYCLES - 1);

    state_e            r_state;
    ch_e               r_ch;
    logic [TW-1:0]     r_timer;
    logic              r_trig_m;
    logic              r_trig_r;
    logic              r_trig_l;
    logic [DIST_W-1:0] r_dist_m;
    logic [DIST_W-1:0] r_dist_r;
    logic [DIST_W-1:0] r_dist_l;
    logic              r_upd;
    logic [1:0]        r_upd_ch;

    logic              w_echo_sel;
    logic              w_level;
    logic              w_rise;
    logic              w_fall;
    logic [DIST_W-1:0] w_count_nxt;
    logic              w_clear;
    logic              w_run;
    logic              w_timeout;
    logic              w_wr_en;
    logic [DIST_W-1:0] w_wr_val;

    // Only the active channel's echo reaches the meter
    always_comb begin
        w_echo_sel = echo_m;
        case (r_ch)
            CH_R:    w_echo_sel = echo_r;
            CH_L:    w_echo_sel = echo_l;
            default: w_echo_sel = echo_m;
        endcase
    end

    assign w_clear   = (r_state == S_WAIT_RISE) && w_rise;
    assign w_run     = (r_state == S_MEASURE);
    assign w_timeout = (r_timer >= T_TOUT);

    ultrasonic_scan3_echo_meter #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_meter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_echo        (w_echo_sel),
        .i_clear       (w_clear),
        .i_run         (w_run),
        .o_level       (w_level),
        .o_rise_c      (w_rise),
        .o_fall_c      (w_fall),
        .o_count_nxt_c (w_count_nxt)
    );

    // Decide whether this cycle terminates a measurement and what to store;
    // a falling edge takes priority over a coincident timeout
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_val = DIST_MAX;
        case (r_state)
            S_WAIT_RISE: begin
                if (!w_rise && w_timeout) begin
                    w_wr_en  = 1'b1;
                    w_wr_val = w_level ? DIST_FAULT : DIST_MAX;
                end
            end
            S_MEASURE: begin
                if (w_fall || w_timeout) begin
                    w_wr_en  = 1'b1;
                    w_wr_val = w_count_nxt;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: trigger, wait for echo, measure, idle gap, next channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_TRIG;
            r_ch     <= CH_M;
            r_timer  <= '0;
            r_trig_m <= 1'b0;
            r_trig_r <= 1'b0;
            r_trig_l <= 1'b0;
        end else begin
            r_trig_m <= 1'b0;
            r_trig_r <= 1'b0;
            r_trig_l <= 1'b0;
            case (r_state)
                S_TRIG: begin
                    if (r_timer == T_TRIG) begin
                        r_state <= S_WAIT_RISE;
                        r_timer <= '0;
                    end else begin
                        r_trig_m <= (r_ch == CH_M);
                        r_trig_r <= (r_ch == CH_R);
                        r_trig_l <= (r_ch == CH_L);
                        r_timer  <= r_timer + TW'(1);
                    end
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_state <= S_MEASURE;
                        r_timer <= r_timer + TW'(1);
                    end else if (w_wr_en) begin
                        r_state <= S_GAP;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_MEASURE: begin
                    if (w_wr_en) begin
                        r_state <= S_GAP;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_timer == T_GAP) begin
                        r_state <= S_TRIG;
                        r_ch    <= next_ch(r_ch);
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_TRIG;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Held distance registers and the one-cycle update strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dist_m <= '0;
            r_dist_r <= '0;
            r_dist_l <= '0;
            r_upd    <= 1'b0;
            r_upd_ch <= 2'd0;
        end else begin
            r_upd <= w_wr_en;
            if (w_wr_en) begin
                r_upd_ch <= r_ch;
                case (r_ch)
                    CH_R:    r_dist_r <= w_wr_val;
                    CH_L:    r_dist_l <= w_wr_val;
                    default: r_dist_m <= w_wr_val;
                endcase
            end
        end
    end

    assign trig_m   = r_trig_m;
    assign trig_r   = r_trig_r;
    assign trig_l   = r_trig_l;
    assign dist_m   = r_dist_m;
    assign dist_r   = r_dist_r;
    assign dist_l   = r_dist_l;
    assign dist_upd = r_upd;
    assign upd_ch   = r_upd_ch;

endmodule

// File: tb/tb_ultrasonic_scan3.sv
// Self-checking bench for ultrasonic_scan3 with shortened timing parameters.
module tb_ultrasonic_scan3;

    localparam int unsigned UNIT = 4;
    localparam int unsigned TRIG = 3;
    localparam int unsigned TOUT = 2000;
    localparam int unsigned GAP  = 10;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       echo_m = 1'b0;
    logic       echo_r = 1'b0;
    logic       echo_l = 1'b0;
    logic       trig_m, trig_r, trig_l;
    logic [7:0] dist_m, dist_r, dist_l;
    logic       dist_upd;
    logic [1:0] upd_ch;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mdl [3];   // expected held distance per channel
    int         cur_ch;    // channel the DUT should fire next

    ultrasonic_scan3 #(
        .UNIT_CYCLES (UNIT),
        .TRIG_CYCLES (TRIG),
        .TIMEOUT_CYC (TOUT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .echo_m   (echo_m),
        .echo_r   (echo_r),
        .echo_l   (echo_l),
        .trig_m   (trig_m),
        .trig_r   (trig_r),
        .trig_l   (trig_l),
        .dist_m   (dist_m),
        .dist_r   (dist_r),
        .dist_l   (dist_l),
        .dist_upd (dist_upd),
        .upd_ch   (upd_ch)
    );

    always #5 clk = ~clk;

    // Distance in whole units for an echo of w clock cycles, clipped at 255
    function automatic logic [7:0] ref_dist(input int w);
        int units;
        units = w / int'(UNIT);
        return (units > 255) ? 8'd255 : 8'(units);
    endfunction

    function automatic logic trig_of(input int ch);
        case (ch)
            0:       return trig_m;
            1:       return trig_r;
            default: return trig_l;
        endcase
    endfunction

    // Drive the selected echo to v; idle echoes get random noise when asked
    task automatic drive_echo(input int ch, input logic v, input bit noisy);
        logic [2:0] e;
        e = noisy ? 3'($urandom) : 3'b000;
        case (ch)
            0:       e[0] = v;
            1:       e[1] = v;
            default: e[2] = v;
        endcase
        {echo_l, echo_r, echo_m} = e;
    endtask

    task automatic pulse_echo(input int ch, input int d, input int w, input bit noisy);
        repeat (d) @(negedge clk);
        for (int i = 0; i < w; i++) begin
            drive_echo(ch, 1'b1, noisy);
            @(negedge clk);
        end
        drive_echo(ch, 1'b0, 1'b0);
    endtask

    // Wait for the trigger of ch, measure its width, note any foreign trigger
    task automatic run_trig(input int ch, output int w, output bit ok, output bit other);
        logic [2:0] tv;
        logic [2:0] mask;
        w = 0; ok = 1'b0; other = 1'b0;
        mask = 3'b001 << ch;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            tv = {trig_l, trig_r, trig_m};
            if ((tv & ~mask) != 3'b000) other = 1'b1;
            if (trig_of(ch)) w++;
            else if (w > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_upd(input int bound, output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (dist_upd) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int w; bit ok; bit other;
        rst_n = 1'b0;
        drive_echo(0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_tests++;
        if ({trig_l, trig_r, trig_m} !== 3'b000) begin
            n_fail++; $display("FAIL reset_trig got=%b exp=000", {trig_l, trig_r, trig_m});
        end
        n_tests++;
        if ({dist_m, dist_r, dist_l} !== 24'h0) begin
            n_fail++; $display("FAIL reset_dist got=%h exp=000000", {dist_m, dist_r, dist_l});
        end
        n_tests++;
        if ({dist_upd, upd_ch} !== 3'b000) begin
            n_fail++; $display("FAIL reset_upd got=%b exp=000", {dist_upd, upd_ch});
        end
        for (int c = 0; c < 3; c++) mdl[c] = 8'd0;
        cur_ch = 0;
        rst_n  = 1'b1;
        run_trig(0, w, ok, other);
        n_tests++;
        if (ok !== 1'b1 || w !== int'(TRIG)) begin
            n_fail++; $display("FAIL reset_trig_m_width got=%0d ok=%0d exp=%0d", w, ok, TRIG);
        end
        n_tests++;
        if (other !== 1'b0) begin
            n_fail++; $display("FAIL reset_trig_rl got=%0d exp=0", other);
        end
    endtask

    task automatic test_echo_m;
        bit ok; int cyc;
        pulse_echo(0, 5, 40, 1'b0);
        wait_upd(20, ok, cyc);
        mdl[0] = ref_dist(40);
        n_tests++;
        if (ok !== 1'b1 || upd_ch !== 2'd0) begin
            n_fail++; $display("FAIL echo_m_upd got ok=%0d ch=%0d exp ok=1 ch=0", ok, upd_ch);
        end
        n_tests++;
        if ({dist_m, dist_r, dist_l} !== {mdl[0], mdl[1], mdl[2]}) begin
            n_fail++; $display("FAIL echo_m_dist got=%h exp=%h", {dist_m, dist_r, dist_l}, {mdl[0], mdl[1], mdl[2]});
        end
        @(negedge clk);
        n_tests++;
        if (dist_upd !== 1'b0) begin
            n_fail++; $display("FAIL echo_m_pulse got=%b exp=0", dist_upd);
        end
        cur_ch = 1;
    endtask

    task automatic test_no_echo_r;
        int w; bit ok; bit other; int cyc;
        run_trig(1, w, ok, other);
        n_tests++;
        if (ok !== 1'b1 || w !== int'(TRIG) || other !== 1'b0) begin
            n_fail++; $display("FAIL noecho_trig got w=%0d ok=%0d other=%0d exp w=%0d", w, ok, other, TRIG);
        end
        wait_upd(int'(TOUT) + 100, ok, cyc);
        mdl[1] = 8'd255;
        n_tests++;
        if (ok !== 1'b1 || cyc < int'(TOUT) - 2 || cyc > int'(TOUT) + 2) begin
            n_fail++; $display("FAIL noecho_latency got=%0d ok=%0d exp=%0d", cyc, ok, TOUT);
        end
        n_tests++;
        if (upd_ch !== 2'd1 || {dist_m, dist_r, dist_l} !== {mdl[0], mdl[1], mdl[2]}) begin
            n_fail++; $display("FAIL noecho_dist got ch=%0d d=%h exp ch=1 d=%h", upd_ch, {dist_m, dist_r, dist_l}, {mdl[0], mdl[1], mdl[2]});
        end
        cur_ch = 2;
    endtask

    task automatic test_sat_l;
        int w; bit ok; bit other; int cyc;
        run_trig(2, w, ok, other);
        n_tests++;
        if (ok !== 1'b1 || w !== int'(TRIG) || other !== 1'b0) begin
            n_fail++; $display("FAIL sat_trig got w=%0d ok=%0d other=%0d exp w=%0d", w, ok, other, TRIG);
        end
        pulse_echo(2, 3, 1500, 1'b1);
        wait_upd(10, ok, cyc);
        mdl[2] = ref_dist(1500);
        n_tests++;
        if (ok !== 1'b1 || upd_ch !== 2'd2) begin
            n_fail++; $display("FAIL sat_upd got ok=%0d ch=%0d exp ok=1 ch=2", ok, upd_ch);
        end
        n_tests++;
        if ({dist_m, dist_r, dist_l} !== {mdl[0], mdl[1], mdl[2]}) begin
            n_fail++; $display("FAIL sat_dist got=%h exp=%h", {dist_m, dist_r, dist_l}, {mdl[0], mdl[1], mdl[2]});
        end
        cur_ch = 0;
    endtask

    task automatic test_stuck_m;
        int w; bit ok; bit other; int cyc;
        drive_echo(0, 1'b1, 1'b0);
        run_trig(0, w, ok, other);
        n_tests++;
        if (ok !== 1'b1 || w !== int'(TRIG)) begin
            n_fail++; $display("FAIL stuck_trig got w=%0d ok=%0d exp=%0d", w, ok, TRIG);
        end
        wait_upd(int'(TOUT) + 100, ok, cyc);
        mdl[0] = 8'd0;
        n_tests++;
        if (ok !== 1'b1 || cyc < int'(TOUT) - 2 || cyc > int'(TOUT) + 2) begin
            n_fail++; $display("FAIL stuck_latency got=%0d ok=%0d exp=%0d", cyc, ok, TOUT);
        end
        n_tests++;
        if (upd_ch !== 2'd0 || {dist_m, dist_r, dist_l} !== {mdl[0], mdl[1], mdl[2]}) begin
            n_fail++; $display("FAIL stuck_dist got ch=%0d d=%h exp ch=0 d=%h", upd_ch, {dist_m, dist_r, dist_l}, {mdl[0], mdl[1], mdl[2]});
        end
        drive_echo(0, 1'b0, 1'b0);
        cur_ch = 1;
    endtask

    task automatic test_back_to_back;
        int w; int d; int pw; bit ok; bit other; int cyc; int ch;
        for (int k = 0; k < 9; k++) begin
            ch = cur_ch;
            d  = int'($urandom_range(1, 40));
            case (k)
                0:       w = 3;
                1:       w = 1020;
                2:       w = 1019;
                default: w = int'($urandom_range(1, 1100));
            endcase
            run_trig(ch, pw, ok, other);
            n_tests++;
            if (ok !== 1'b1 || pw !== int'(TRIG) || other !== 1'b0) begin
                n_fail++; $display("FAIL b2b_trig k=%0d ch=%0d got w=%0d ok=%0d other=%0d exp w=%0d", k, ch, pw, ok, other, TRIG);
            end
            pulse_echo(ch, d, w, 1'b1);
            wait_upd(10, ok, cyc);
            mdl[2'(ch)] = ref_dist(w);
            n_tests++;
            if (ok !== 1'b1 || upd_ch !== 2'(ch)) begin
                n_fail++; $display("FAIL b2b_upd k=%0d got ok=%0d ch=%0d exp ch=%0d", k, ok, upd_ch, ch);
            end
            n_tests++;
            if ({dist_m, dist_r, dist_l} !== {mdl[0], mdl[1], mdl[2]}) begin
                n_fail++; $display("FAIL b2b_dist k=%0d w=%0d got=%h exp=%h", k, w, {dist_m, dist_r, dist_l}, {mdl[0], mdl[1], mdl[2]});
            end
            @(negedge clk);
            n_tests++;
            if (dist_upd !== 1'b0) begin
                n_fail++; $display("FAIL b2b_pulse k=%0d got=%b exp=0", k, dist_upd);
            end
            cur_ch = (cur_ch + 1) % 3;
        end
    endtask

    task automatic test_reset_mid;
        int w; bit ok; bit other; int cyc;
        run_trig(1, w, ok, other);
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL rmid_trig_r got ok=%0d exp=1", ok);
        end
        repeat (2) @(negedge clk);
        drive_echo(1, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) mdl[c] = 8'd0;
        n_tests++;
        if ({trig_l, trig_r, trig_m, dist_upd, upd_ch} !== 6'b0) begin
            n_fail++; $display("FAIL rmid_ctrl got=%b exp=000000", {trig_l, trig_r, trig_m, dist_upd, upd_ch});
        end
        n_tests++;
        if ({dist_m, dist_r, dist_l} !== 24'h0) begin
            n_fail++; $display("FAIL rmid_dist got=%h exp=000000", {dist_m, dist_r, dist_l});
        end
        drive_echo(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cur_ch = 0;
        run_trig(0, w, ok, other);
        n_tests++;
        if (ok !== 1'b1 || w !== int'(TRIG) || other !== 1'b0) begin
            n_fail++; $display("FAIL rmid_restart got w=%0d ok=%0d other=%0d exp w=%0d", w, ok, other, TRIG);
        end
        pulse_echo(0, 4, 20, 1'b0);
        wait_upd(10, ok, cyc);
        mdl[0] = ref_dist(20);
        n_tests++;
        if (ok !== 1'b1 || upd_ch !== 2'd0 || {dist_m, dist_r, dist_l} !== {mdl[0], mdl[1], mdl[2]}) begin
            n_fail++; $display("FAIL rmid_meas got ok=%0d ch=%0d d=%h exp ch=0 d=%h", ok, upd_ch, {dist_m, dist_r, dist_l}, {mdl[0], mdl[1], mdl[2]});
        end
    endtask

    initial begin
        test_reset();
        test_echo_m();
        test_no_echo_r();
        test_sat_l();
        test_stuck_m();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the run hangs
    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1);
    end

endmodule
